// File: rtl/rtt_stats_collector_pkg.sv
// rtt_stats_collector shared definitions: FSM encoding,
// IOQ ctrl constants, header field positions, report word builders.
package rtt_stats_collector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DROP_TS,
    ST_THRU,
    ST_CAP_RX,
    ST_CAP_TX,
    ST_RPT_HDR,
    ST_RPT_DATA,
    ST_RPT_END
  } state_t;

  localparam logic [7:0] CTRL_HDR  = 8'hFF;
  localparam logic [7:0] CTRL_DATA = 8'h00;
  localparam logic [7:0] CTRL_EOP  = 8'h01;

  localparam int HDR_DST_LO  = 48;
  localparam int HDR_WLEN_LO = 32;
  localparam int HDR_SRC_LO  = 16;
  localparam int HDR_BLEN_LO = 0;
  localparam int TRL_CH_LO   = 56;
  localparam int TS_W        = 32;
  localparam int CH_W        = 3;

  function automatic logic [63:0] rpt_hdr_word(
    input logic [CH_W-1:0] ch,
    input logic [15:0]     n
  );
    logic [63:0] w;
    logic [15:0] wlen;
    wlen = n + 16'd1;
    w = '0;
    w[HDR_DST_LO +: 16]  = 16'd1 << (2 * ch + 1);
    w[HDR_WLEN_LO +: 16] = wlen;
    w[HDR_SRC_LO +: 16]  = 16'd0;
    w[HDR_BLEN_LO +: 16] = {wlen[12:0], 3'b000};
    return w;
  endfunction

  function automatic logic [63:0] rpt_end_word(
    input logic [CH_W-1:0] ch,
    input logic [15:0]     n
  );
    logic [63:0] w;
    w = '0;
    w[TRL_CH_LO +: 8] = {{(8-CH_W){1'b0}}, ch};
    w[15:0] = n;
    return w;
  endfunction

endpackage

// File: rtl/rtt_sample_buf.sv
// rtt_sample_buf: per-channel sample FIFO with occupancy count.
// Ports: clk, reset (sync, high), wr_en/wr_data, rd_en/rd_data
// (fall-through head), count, full, empty. Writes when full ignored.
module rtt_sample_buf #(
  parameter int W          = 64,
  parameter int DEPTH_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [W-1:0]        wr_data,
  input  logic                rd_en,
  output logic [W-1:0]        rd_data,
  output logic [DEPTH_BITS:0] count,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT =
    {1'b1, {DEPTH_BITS{1'b0}}};

  logic [W-1:0] mem [DEPTH];

  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                  do_wr, do_rd;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem[rd_ptr_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + DEPTH_BITS'(do_wr);
    rd_ptr_d = rd_ptr_q + DEPTH_BITS'(do_rd);
    cnt_d    = cnt_q;
    unique case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/rtt_stats_collector.sv
// rtt_stats_collector: strips timestamps from IOQ packets, captures
// RTT samples for CPU-queue packets, and emits per-channel reports.
// Ports: clk, reset (sync, high); in_data/in_ctrl/in_wr/in_rdy;
// out_data/out_ctrl/out_wr/out_rdy; flush_req[NUM_CH];
// report_cnt, drop_cnt (32-bit, wrapping).
// Macro RTT_STATS_DELTA_EN: sample low word = tx_ts - rx_ts.
module rtt_stats_collector
  import rtt_stats_collector_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int NUM_CH        = 2,
  parameter int DEPTH_BITS    = 4,
  parameter int REPORT_THRESH = 2 ** DEPTH_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [NUM_CH-1:0]     flush_req,
  output logic [31:0]           report_cnt,
  output logic [31:0]           drop_cnt
);

  localparam int CNT_W = DEPTH_BITS + 1;

  // Input FIFO, 4 deep, head visible combinationally
  logic [DATA_WIDTH-1:0] ififo_data_mem [4];
  logic [CTRL_WIDTH-1:0] ififo_ctrl_mem [4];
  logic [1:0] iwr_ptr_q, iwr_ptr_d;
  logic [1:0] ird_ptr_q, ird_ptr_d;
  logic [2:0] icnt_q, icnt_d;
  logic       push, pop;

  logic [DATA_WIDTH-1:0] head_data;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic                  head_vld;
  logic                  head_is_hdr;
  logic                  head_eop;
  logic                  adv;

  assign push   = in_wr && (icnt_q != 3'd4);
  assign in_rdy = (icnt_q < 3'd3);

  assign head_data   = ififo_data_mem[ird_ptr_q];
  assign head_ctrl   = ififo_ctrl_mem[ird_ptr_q];
  assign head_vld    = (icnt_q != 3'd0);
  assign head_is_hdr = (head_ctrl == CTRL_WIDTH'(CTRL_HDR));
  assign head_eop    = |head_ctrl;
  assign adv         = head_vld && out_rdy;

  always_comb begin
    iwr_ptr_d = iwr_ptr_q + 2'(push);
    ird_ptr_d = ird_ptr_q + 2'(pop);
    icnt_d    = icnt_q + 3'(push) - 3'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iwr_ptr_q <= '0;
      ird_ptr_q <= '0;
      icnt_q    <= '0;
    end else begin
      iwr_ptr_q <= iwr_ptr_d;
      ird_ptr_q <= ird_ptr_d;
      icnt_q    <= icnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ififo_data_mem[iwr_ptr_q] <= in_data;
      ififo_ctrl_mem[iwr_ptr_q] <= in_ctrl;
    end
  end

  // State and datapath registers
  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [TS_W-1:0]   rx_ts_q, rx_ts_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [31:0]       rpt_cnt_q, rpt_cnt_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;
  logic [NUM_CH-1:0] pend_q, pend_d;

  // Channel buffers
  logic [63:0]      smp_word;
  logic [63:0]      buf_dout [NUM_CH];
  logic [CNT_W-1:0] buf_cnt  [NUM_CH];
  logic [NUM_CH-1:0] buf_full, buf_empty;
  logic [NUM_CH-1:0] buf_wr, buf_rd;

`ifdef RTT_STATS_DELTA_EN
  assign smp_word = {rx_ts_q, head_data[31:0] - rx_ts_q};
`else
  assign smp_word = {rx_ts_q, head_data[31:0]};
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rtt_sample_buf #(
      .W          (64),
      .DEPTH_BITS (DEPTH_BITS)
    ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (buf_wr[g]),
      .wr_data (smp_word),
      .rd_en   (buf_rd[g]),
      .rd_data (buf_dout[g]),
      .count   (buf_cnt[g]),
      .full    (buf_full[g]),
      .empty   (buf_empty[g])
    );
  end

  // Channel selection: lowest index wins in both searches
  logic              stat_hit;
  logic [CH_W-1:0]   stat_ch;
  logic              rpt_go;
  logic [CH_W-1:0]   rpt_sel;
  logic [CNT_W-1:0]  rpt_sel_cnt;
  logic              sel_full;
  logic [63:0]       sel_dout;

  always_comb begin
    stat_hit    = 1'b0;
    stat_ch     = '0;
    rpt_go      = 1'b0;
    rpt_sel     = '0;
    rpt_sel_cnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (head_data[HDR_DST_LO + 2 * i + 1]) begin
        stat_hit = 1'b1;
        stat_ch  = CH_W'(i);
      end
      if ((int'(buf_cnt[i]) >= REPORT_THRESH) ||
          (pend_q[i] && !buf_empty[i])) begin
        rpt_go      = 1'b1;
        rpt_sel     = CH_W'(i);
        rpt_sel_cnt = buf_cnt[i];
      end
    end
  end

  always_comb begin
    sel_full = 1'b0;
    sel_dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_full = buf_full[i];
        sel_dout = buf_dout[i];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (out_rdy) begin
          if (rpt_go) state_d = ST_RPT_HDR;
          else if (head_vld && head_is_hdr)
            state_d = stat_hit ? ST_CAP_RX : ST_DROP_TS;
        end
      end
      ST_DROP_TS: if (adv) state_d = ST_THRU;
      ST_THRU:    if (adv && head_eop) state_d = ST_IDLE;
      ST_CAP_RX:  if (adv) state_d = ST_CAP_TX;
      ST_CAP_TX:  if (adv && head_eop) state_d = ST_IDLE;
      ST_RPT_HDR: if (out_rdy) state_d = ST_RPT_DATA;
      ST_RPT_DATA: begin
        if (out_rdy && rem_q == CNT_W'(1)) state_d = ST_RPT_END;
      end
      ST_RPT_END: if (out_rdy) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  logic wr_smp, rd_smp;

  always_comb begin
    out_wr   = 1'b0;
    out_data = '0;
    out_ctrl = '0;
    pop      = 1'b0;
    wr_smp   = 1'b0;
    rd_smp   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Reports take priority; stray non-header words are dropped
        if (out_rdy && !rpt_go && head_vld) begin
          pop = 1'b1;
          if (head_is_hdr && !stat_hit) begin
            out_wr   = 1'b1;
            out_data = head_data;
            out_ctrl = head_ctrl;
          end
        end
      end
      ST_DROP_TS: pop = adv;
      ST_THRU: begin
        pop      = adv;
        out_wr   = adv;
        out_data = head_data;
        out_ctrl = head_ctrl;
      end
      ST_CAP_RX: pop = adv;
      ST_CAP_TX: begin
        pop    = adv;
        wr_smp = adv && head_eop;
      end
      ST_RPT_HDR: begin
        out_wr   = out_rdy;
        out_data = DATA_WIDTH'(rpt_hdr_word(ch_q, 16'(n_q)));
        out_ctrl = CTRL_WIDTH'(CTRL_HDR);
      end
      ST_RPT_DATA: begin
        out_wr   = out_rdy;
        out_data = DATA_WIDTH'(sel_dout);
        out_ctrl = CTRL_WIDTH'(CTRL_DATA);
        rd_smp   = out_rdy;
      end
      ST_RPT_END: begin
        out_wr   = out_rdy;
        out_data = DATA_WIDTH'(rpt_end_word(ch_q, 16'(n_q)));
        out_ctrl = CTRL_WIDTH'(CTRL_EOP);
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      buf_wr[i] = wr_smp && !sel_full && (ch_q == CH_W'(i));
      buf_rd[i] = rd_smp && (ch_q == CH_W'(i));
    end
  end

  // Datapath next values
  logic go_rpt, go_cap;

  assign go_rpt = (state_q == ST_IDLE) && out_rdy && rpt_go;
  assign go_cap = (state_q == ST_IDLE) && out_rdy && !rpt_go &&
                  head_vld && head_is_hdr && stat_hit;

  always_comb begin
    ch_d       = ch_q;
    rx_ts_d    = rx_ts_q;
    n_d        = n_q;
    rem_d      = rem_q;
    rpt_cnt_d  = rpt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    pend_d     = pend_q | flush_req;
    if (go_rpt) begin
      // n frozen here; later samples wait for the next report
      ch_d  = rpt_sel;
      n_d   = rpt_sel_cnt;
      rem_d = rpt_sel_cnt;
      for (int i = 0; i < NUM_CH; i++)
        if (rpt_sel == CH_W'(i)) pend_d[i] = 1'b0;
    end
    if (go_cap) ch_d = stat_ch;
    if (state_q == ST_CAP_RX && adv) rx_ts_d = head_data[31:0];
    if (wr_smp && sel_full) drop_cnt_d = drop_cnt_q + 32'd1;
    if (rd_smp) rem_d = rem_q - 1'b1;
    if (state_q == ST_RPT_END && out_rdy)
      rpt_cnt_d = rpt_cnt_q + 32'd1;
    // A flush on an empty channel is dropped without a report
    pend_d = pend_d & ~buf_empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q       <= '0;
      rx_ts_q    <= '0;
      n_q        <= '0;
      rem_q      <= '0;
      rpt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      pend_q     <= '0;
    end else begin
      ch_q       <= ch_d;
      rx_ts_q    <= rx_ts_d;
      n_q        <= n_d;
      rem_q      <= rem_d;
      rpt_cnt_q  <= rpt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      pend_q     <= pend_d;
    end
  end

  assign report_cnt = rpt_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_rtt_stats_collector.sv
// Testbench for rtt_stats_collector: two instances
// (threshold 2 and never-triggering threshold), directed vectors.
module tb_rtt_stats_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        in_wr = 1'b0;
  logic        out_rdy = 1'b0;
  logic        sel_b = 1'b0;
  logic [1:0]  flush_a = '0;
  logic [1:0]  flush_b = '0;

  logic        in_rdy_a, in_rdy_b, out_wr_a, out_wr_b;
  logic [63:0] out_data_a, out_data_b;
  logic [7:0]  out_ctrl_a, out_ctrl_b;
  logic [31:0] report_cnt_a, report_cnt_b;
  logic [31:0] drop_cnt_a, drop_cnt_b;
  logic        in_wr_a, in_wr_b, cur_rdy;

  int n_chk = 0;
  int n_fail = 0;

  logic [71:0] qa[$];
  logic [71:0] qb[$];

  assign in_wr_a = in_wr && !sel_b;
  assign in_wr_b = in_wr && sel_b;
  assign cur_rdy = sel_b ? in_rdy_b : in_rdy_a;

  always #5 clk = ~clk;

  rtt_stats_collector #(
    .NUM_CH(2), .DEPTH_BITS(2), .REPORT_THRESH(2)
  ) dut_a (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .in_wr(in_wr_a), .in_rdy(in_rdy_a),
    .out_data(out_data_a), .out_ctrl(out_ctrl_a),
    .out_wr(out_wr_a), .out_rdy(out_rdy),
    .flush_req(flush_a),
    .report_cnt(report_cnt_a), .drop_cnt(drop_cnt_a)
  );

  rtt_stats_collector #(
    .NUM_CH(2), .DEPTH_BITS(2), .REPORT_THRESH(5)
  ) dut_b (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .in_wr(in_wr_b), .in_rdy(in_rdy_b),
    .out_data(out_data_b), .out_ctrl(out_ctrl_b),
    .out_wr(out_wr_b), .out_rdy(out_rdy),
    .flush_req(flush_b),
    .report_cnt(report_cnt_b), .drop_cnt(drop_cnt_b)
  );

  // Inputs change at posedge+1, so negedge sees the transfer values
  always @(negedge clk) begin
    if (!reset) begin
      if (out_wr_a) qa.push_back({out_ctrl_a, out_data_a});
      if (out_wr_b) qb.push_back({out_ctrl_b, out_data_b});
    end
  end

  function automatic logic [71:0] smp(input logic [31:0] rx,
                                      input logic [31:0] tx);
`ifdef RTT_STATS_DELTA_EN
    return {8'h00, rx, tx - rx};
`else
    return {8'h00, rx, tx};
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] c, input logic [63:0] d);
    int k;
    k = 0;
    in_ctrl = c;
    in_data = d;
    in_wr = 1'b1;
    while (!cur_rdy && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) begin
      n_fail++;
      $display("FAIL put_timeout: in_rdy low for %0d cycles, need 1", k);
    end
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic stat_pkt(input int ch, input logic [31:0] rx,
                          input logic [31:0] tx);
    logic [15:0] dst;
    dst = '0;
    dst[2 * ch + 1] = 1'b1;
    put(8'hFF, {dst, 48'h0});
    put(8'h00, {32'h0, rx});
    put(8'h01, {32'h0, tx});
  endtask

  task automatic wait_words(input bit b, input int n, input int budget);
    int k;
    k = 0;
    while ((b ? qb.size() : qa.size()) < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    n_chk++;
    if ((b ? qb.size() : qa.size()) < n) begin
      n_fail++;
      $display("FAIL wait_words: got %0d words, need %0d",
               b ? qb.size() : qa.size(), n);
    end
  endtask

  task automatic pulse_flush_b(input logic [1:0] m);
    flush_b = m;
    @(posedge clk); #1;
    flush_b = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    out_rdy = 1'b1;
    #1;
    n_chk++;
    if (out_wr_a !== 1'b0 || out_wr_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_wr: got %b/%b, need 0/0",
               out_wr_a, out_wr_b);
    end
    n_chk++;
    if (in_rdy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_rdy: got %b, need 1", in_rdy_a);
    end
    n_chk++;
    if (report_cnt_a !== 32'd0 || drop_cnt_a !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d, need 0/0",
               report_cnt_a, drop_cnt_a);
    end
    idle(1);
  endtask

  task automatic test_passthrough;
    logic [71:0] exp [4];
    exp[0] = {8'hFF, 64'h0001_0005_0000_0028};
    exp[1] = {8'h00, 64'h0000_0000_0000_1111};
    exp[2] = {8'h00, 64'h0000_0000_0000_2222};
    exp[3] = {8'h08, 64'h0000_0000_0000_3333};
    sel_b = 1'b0;
    qa.delete();
    put(exp[0][71:64], exp[0][63:0]);
    put(8'h00, 64'h0000_0000_DEAD_BEEF);
    put(exp[1][71:64], exp[1][63:0]);
    put(exp[2][71:64], exp[2][63:0]);
    put(exp[3][71:64], exp[3][63:0]);
    wait_words(1'b0, 4, 50);
    idle(5);
    n_chk++;
    if (qa.size() != 4) begin
      n_fail++;
      $display("FAIL thru_count: got %0d words, need 4", qa.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (qa.size() > i && qa[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL thru_word%0d: got %h, need %h",
                 i, qa[i], exp[i]);
      end
    end
  endtask

  task automatic test_report;
    logic [71:0] exp [4];
    exp[0] = {8'hFF, 64'h0008_0003_0000_0018};
    exp[1] = smp(32'h100, 32'h180);
    exp[2] = smp(32'h200, 32'h290);
    exp[3] = {8'h01, 64'h0100_0000_0000_0002};
    qa.delete();
    stat_pkt(1, 32'h100, 32'h180);
    stat_pkt(1, 32'h200, 32'h290);
    wait_words(1'b0, 4, 60);
    idle(5);
    n_chk++;
    if (qa.size() != 4) begin
      n_fail++;
      $display("FAIL rpt_count: got %0d words, need 4", qa.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (qa.size() > i && qa[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL rpt_word%0d: got %h, need %h",
                 i, qa[i], exp[i]);
      end
    end
    n_chk++;
    if (report_cnt_a !== 32'd1 || drop_cnt_a !== 32'd0) begin
      n_fail++;
      $display("FAIL rpt_cnt: got %0d/%0d, need 1/0",
               report_cnt_a, drop_cnt_a);
    end
  endtask

  task automatic test_reset_mid_report;
    qa.delete();
    stat_pkt(0, 32'h10, 32'h20);
    stat_pkt(0, 32'h30, 32'h40);
    wait_words(1'b0, 2, 60);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (out_wr_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_out_wr: got %b, need 0", out_wr_a);
    end
    n_chk++;
    if (report_cnt_a !== 32'd0 || drop_cnt_a !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_cnt: got %0d/%0d, need 0/0",
               report_cnt_a, drop_cnt_a);
    end
    idle(20);
    n_chk++;
    if (qa.size() != 2) begin
      n_fail++;
      $display("FAIL rst_mid_tail: got %0d words, need 2", qa.size());
    end
    qa.delete();
    stat_pkt(0, 32'h50, 32'h60);
    idle(10);
    n_chk++;
    if (qa.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_early: got %0d words, need 0", qa.size());
    end
    stat_pkt(0, 32'h70, 32'h80);
    wait_words(1'b0, 4, 60);
    idle(3);
    n_chk++;
    if (qa.size() < 4 || qa[1] !== smp(32'h50, 32'h60) ||
        qa[3] !== {8'h01, 64'h0000_0000_0000_0002}) begin
      n_fail++;
      $display("FAIL rst_mid_new: got %0d words, need 4 with new data",
               qa.size());
    end
    n_chk++;
    if (report_cnt_a !== 32'd1) begin
      n_fail++;
      $display("FAIL rst_mid_rptcnt: got %0d, need 1", report_cnt_a);
    end
  endtask

  task automatic test_overflow;
    sel_b = 1'b1;
    qb.delete();
    for (int i = 0; i < 5; i++)
      stat_pkt(0, 32'h1000 + i, 32'h2000 + i);
    idle(10);
    n_chk++;
    if (drop_cnt_b !== 32'd1) begin
      n_fail++;
      $display("FAIL ovf_drop: got %0d, need 1", drop_cnt_b);
    end
    n_chk++;
    if (qb.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_quiet: got %0d words, need 0", qb.size());
    end
    pulse_flush_b(2'b01);
    wait_words(1'b1, 6, 60);
    idle(5);
    n_chk++;
    if (qb.size() != 6) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d words, need 6", qb.size());
    end
    n_chk++;
    if (qb.size() > 5 &&
        (qb[0] !== {8'hFF, 64'h0002_0005_0000_0028} ||
         qb[4] !== smp(32'h1003, 32'h2003) ||
         qb[5] !== {8'h01, 64'h0000_0000_0000_0004})) begin
      n_fail++;
      $display("FAIL ovf_words: got %h %h %h, need hdr n4 last 1003",
               qb[0], qb[4], qb[5]);
    end
  endtask

  task automatic test_flush;
    qb.delete();
    for (int i = 0; i < 3; i++)
      stat_pkt(0, 32'h300 + i, 32'h400 + i);
    idle(10);
    out_rdy = 1'b0;
    pulse_flush_b(2'b11);
    idle(10);
    n_chk++;
    if (qb.size() != 0 || out_wr_b !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_hold: got %0d words, need 0", qb.size());
    end
    out_rdy = 1'b1;
    wait_words(1'b1, 5, 40);
    idle(10);
    pulse_flush_b(2'b10);
    idle(10);
    n_chk++;
    if (qb.size() != 5) begin
      n_fail++;
      $display("FAIL flush_count: got %0d words, need 5", qb.size());
    end
    n_chk++;
    if (qb.size() > 4 &&
        (qb[0] !== {8'hFF, 64'h0002_0004_0000_0020} ||
         qb[1] !== smp(32'h300, 32'h400) ||
         qb[4] !== {8'h01, 64'h0000_0000_0000_0003})) begin
      n_fail++;
      $display("FAIL flush_words: got %h %h %h, need hdr n3",
               qb[0], qb[1], qb[4]);
    end
    n_chk++;
    if (report_cnt_b !== 32'd2) begin
      n_fail++;
      $display("FAIL flush_rptcnt: got %0d, need 2", report_cnt_b);
    end
  endtask

  task automatic test_priority;
    logic [71:0] exp [7];
    exp[0] = {8'hFF, 64'h0002_0002_0000_0010};
    exp[1] = smp(32'h520, 32'h620);
    exp[2] = {8'h01, 64'h0000_0000_0000_0001};
    exp[3] = {8'hFF, 64'h0008_0003_0000_0018};
    exp[4] = smp(32'h500, 32'h600);
    exp[5] = smp(32'h510, 32'h610);
    exp[6] = {8'h01, 64'h0100_0000_0000_0002};
    qb.delete();
    stat_pkt(1, 32'h500, 32'h600);
    stat_pkt(1, 32'h510, 32'h610);
    stat_pkt(0, 32'h520, 32'h620);
    idle(10);
    pulse_flush_b(2'b11);
    wait_words(1'b1, 7, 80);
    idle(5);
    n_chk++;
    if (qb.size() != 7) begin
      n_fail++;
      $display("FAIL prio_count: got %0d words, need 7", qb.size());
    end
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (qb.size() > i && qb[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL prio_word%0d: got %h, need %h",
                 i, qb[i], exp[i]);
      end
    end
    n_chk++;
    if (report_cnt_b !== 32'd4) begin
      n_fail++;
      $display("FAIL prio_rptcnt: got %0d, need 4", report_cnt_b);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_report();
    test_reset_mid_report();
    test_overflow();
    test_flush();
    test_priority();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rtt_stats_collector.md
RTT_STATS_COLLECTOR -- requirements
Module: rtt_stats_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, datapath width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8, ctrl width.
REQ-003 SHALL have parameter NUM_CH, default 2, number of stat channels (1..8); channel i matches IOQ dst-port bit 2*i+1 (CPU queue i).
REQ-004 SHALL have parameter DEPTH_BITS, default 4, per-channel sample buffer depth 2**DEPTH_BITS.
REQ-005 SHALL have parameter REPORT_THRESH, default 2**DEPTH_BITS, buffered-sample count that triggers a report (1..2**DEPTH_BITS).
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 synchronous, active-high; in_data in DATA_WIDTH; in_ctrl in CTRL_WIDTH; in_wr in 1; in_rdy out 1; out_data out DATA_WIDTH; out_ctrl out CTRL_WIDTH; out_wr out 1; out_rdy in 1; flush_req in NUM_CH, per-channel report request pulse; report_cnt out 32, reports emitted; drop_cnt out 32, samples lost.

Function
REQ-007 SHALL buffer input in a 4-deep fall-through FIFO; in_rdy = not nearly_full.
REQ-008 SHALL advance any state only when input FIFO non-empty and out_rdy high (report states need only out_rdy).
REQ-009 SHALL implement states IDLE, DROP_TS, THRU, CAP_RX, CAP_TX, RPT_HDR, RPT_DATA, RPT_END.
REQ-010 IDLE, header word (ctrl 0xFF): if any channel dst bit set, consume without forwarding, latch lowest matching channel index, -> CAP_RX; else forward header, -> DROP_TS.
REQ-011 DROP_TS: consume one word (timestamp) without forwarding, -> THRU.
REQ-012 THRU: forward each word; on nonzero ctrl -> IDLE.
REQ-013 CAP_RX: latch in_data[31:0] as rx_ts, -> CAP_TX.
REQ-014 CAP_TX: consume words; on nonzero ctrl write sample {rx_ts, in_data[31:0]} to latched channel buffer, -> IDLE; if buffer full, discard sample and increment drop_cnt.
REQ-015 In IDLE, before consuming input, if any channel has count >= REPORT_THRESH or a pending non-empty flush, SHALL select lowest such index and -> RPT_HDR.
REQ-016 flush_req pulses SHALL be held pending per channel until that channel's report starts; flush of empty channel SHALL be cleared with no report.
REQ-017 RPT_HDR: emit ctrl 0xFF, data {dst = 1<<(2*ch+1) [63:48], word_len = n+1 [47:32], src 0 [31:16], byte_len = 8*(n+1) [15:0]}, n = count at entry (frozen); -> RPT_DATA.
REQ-018 RPT_DATA: emit n words, ctrl 0x00, one sample each, oldest first, reading buffer one per beat; -> RPT_END after nth.
REQ-019 RPT_END: emit ctrl 0x01, data {ch index [63:56], zero, n [15:0]}; increment report_cnt; -> IDLE.
REQ-020 Samples written during a report SHALL remain for the next report (n frozen).
REQ-021 Counters SHALL wrap at 2**32.
REQ-022 out_wr SHALL be combinational from state, FIFO empty and out_rdy; zero-latency fall-through.

Reset
REQ-023 On reset: state IDLE, buffers emptied, pending flushes cleared, report_cnt = drop_cnt = 0, out_wr = 0, input FIFO emptied.
REQ-024 Reset mid-packet or mid-report SHALL abort it; no partial output continues afterwards.

Configuration
REQ-025 Macro RTT_STATS_DELTA_EN: defined -> sample word = {rx_ts, tx_ts - rx_ts mod 2**32}; undefined -> {rx_ts, tx_ts}.

Structure
REQ-026 Shared package SHALL hold state encodings, ctrl constants (0xFF, 0x00, 0x01), IOQ header field positions.
REQ-027 Per-channel buffer SHALL be sub-module rtt_sample_buf (sync FIFO, count, full, empty), instantiated NUM_CH times.

Verification
REQ-028 Non-stat packet dst 0x0001, 5 words -> 4 words out, timestamp word removed, ctrl unchanged.
REQ-029 NUM_CH=2, REPORT_THRESH=2, two ch1 packets rx 0x100/tx 0x180, rx 0x200/tx 0x290 -> report dst 0x0008, word_len 3, byte_len 24, words {0x100,0x180},{0x200,0x290}, trailer ch 1 n 2; report_cnt 1 (DELTA_EN: low halves 0x80, 0x90).
REQ-030 Fill ch0 to depth with REPORT_THRESH > depth, send one more -> drop_cnt 1, no extra word.
REQ-031 flush_req ch0 with 3 samples while out_rdy low -> report n 3 starts after out_rdy rises; flush on empty ch1 -> no output.
REQ-032 Both channels at threshold simultaneously -> ch0 report fully precedes ch1 report.
REQ-033 Reset asserted mid-RPT_DATA -> out_wr 0 next cycle, counters 0, next report only after new samples.
